dmem_arbiter: RTL

//  Sequences and shares the single-port data memory in the MEM stage between
//  the pipeline (MEM-stage loads/stores) and a secondary requester (loader/debug).
//  It runs each access for a fixed number of memory cycles, stalls the pipeline

---
 rtl/dmem_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data memory between the MEM-stage pipeline and a secondary requester
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_memread,
    input  logic              p_memwrite,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state_q;
    logic              sec_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] s_rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     starve_q;
    logic              p_req;
    logic              grant_s;
    logic              in_acc;
    logic              in_resp;
    assign p_req   = p_memread | p_memwrite;
    assign grant_s = s_req & (~p_req | starve_q == SW'(STARVE_MAX));
    assign rdata_d = we_q ? '0 : mem_rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            p_rdata_q <= '0;
            s_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (grant_s | p_req) begin
                    state_q  <= ACCESS;
                    sec_q    <= grant_s;
                    we_q     <= grant_s ? s_we : p_memwrite;
                    addr_q   <= grant_s ? s_addr : p_addr;
                    wdata_q  <= grant_s ? s_wdata : p_wdata;
                    cnt_q    <= CW'(MEM_LAT - 1);
                    // a pipeline grant with s_req pending implies starve_q is below the limit
                    starve_q <= grant_s ? '0 : starve_q + SW'(s_req);
                end
                ACCESS: if (cnt_q == '0) begin
                    state_q <= RESP;
                    if (sec_q) s_rdata_q <= rdata_d;
                    else p_rdata_q <= rdata_d;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_acc    = state_q == ACCESS & ~rst;
    assign in_resp   = state_q == RESP & ~rst;
    assign mem_read  = in_acc & ~we_q;
    assign mem_write = in_acc & we_q;
    assign mem_addr  = in_acc ? addr_q : '0;
    assign mem_wdata = in_acc ? wdata_q : '0;
    assign p_stall   = p_req & ~(in_resp & ~sec_q) & ~rst;
    assign s_ack     = in_resp & sec_q;
    assign p_rdata   = rst ? '0 : p_rdata_q;
    assign s_rdata   = rst ? '0 : s_rdata_q;
endmodule
